// File: rtl/dds_update_scheduler_if.sv
// Request/issue bundle between the PID output paths, the update scheduler
// and dds_controller. The master side drives requests and dds_done_in.
interface dds_update_scheduler_if #(
    parameter int DROP_W = 16
);
    logic [47:0]       freq_in;
    logic              freq_dv_in;
    logic [13:0]       phase_in;
    logic              phase_dv_in;
    logic [9:0]        amp_in;
    logic              amp_dv_in;
    logic              dds_done_in;
    logic [47:0]       freq_out;
    logic [13:0]       phase_out;
    logic [9:0]        amp_out;
    logic              freq_dv_out;
    logic              phase_dv_out;
    logic              amp_dv_out;
    logic              busy_out;
    logic              timeout_out;
    logic [DROP_W-1:0] drop_count_out;

    modport master (
        output freq_in, freq_dv_in, phase_in, phase_dv_in, amp_in, amp_dv_in, dds_done_in,
        input  freq_out, phase_out, amp_out, freq_dv_out, phase_dv_out, amp_dv_out,
               busy_out, timeout_out, drop_count_out
    );

    modport slave (
        input  freq_in, freq_dv_in, phase_in, phase_dv_in, amp_in, amp_dv_in, dds_done_in,
        output freq_out, phase_out, amp_out, freq_dv_out, phase_dv_out, amp_dv_out,
               busy_out, timeout_out, drop_count_out
    );
endinterface

// File: rtl/dds_update_scheduler.sv
// Coalesces frequency/phase/amplitude update requests and issues them to
// dds_controller one at a time, round-robin, with done/hold-off/watchdog pacing.
module dds_update_scheduler #(
    parameter int HOLDOFF_CYCLES = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int DROP_W         = 16
) (
    input  logic                  clk_in,
    input  logic                  reset_n_in,
    dds_update_scheduler_if.slave io_bus
);
    localparam int WAIT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int HOLD_W = (HOLDOFF_CYCLES > 2) ? $clog2(HOLDOFF_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLDOFF} state_t;

    state_t            r_state, w_state_next;
    logic [2:0]        r_pend, w_pend_next, w_dv_in, w_grant_oh, w_drop;
    logic [2:0]        r_dv, w_dv_next;
    logic [1:0]        r_rr_ptr, r_sel, w_c0, w_c1, w_c2, w_grant_idx;
    logic              w_any, w_issue;
    logic [47:0]       r_freq_val, r_freq_out;
    logic [13:0]       r_phase_val, r_phase_out;
    logic [9:0]        r_amp_val, r_amp_out;
    logic [WAIT_W-1:0] r_wait_cnt, w_wait_next;
    logic [HOLD_W-1:0] r_hold_cnt, w_hold_next;
    logic              r_timeout, w_timeout_next;
    logic [DROP_W-1:0] r_drop_cnt;
    logic [DROP_W:0]   w_drop_sum;

    // Field indices: 0 = freq, 1 = phase, 2 = amp.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    assign w_dv_in = {io_bus.amp_dv_in, io_bus.phase_dv_in, io_bus.freq_dv_in};
    assign w_c0    = r_rr_ptr;
    assign w_c1    = rr_next(w_c0);
    assign w_c2    = rr_next(w_c1);

    always_comb begin
        w_any       = 1'b1;
        w_grant_idx = w_c0;
        if (r_pend[w_c0])      w_grant_idx = w_c0;
        else if (r_pend[w_c1]) w_grant_idx = w_c1;
        else if (r_pend[w_c2]) w_grant_idx = w_c2;
        else                   w_any       = 1'b0;
    end

    assign w_grant_oh = w_issue ? (3'b001 << w_grant_idx) : 3'b000;

    // A field granted on the same edge as a new request keeps its pend bit
    // without counting a drop: the old value is the one being issued.
    for (genvar gi = 0; gi < 3; gi++) begin : g_pend
        assign w_pend_next[gi] = (r_pend[gi] & ~w_grant_oh[gi]) | w_dv_in[gi];
        assign w_drop[gi]      = w_dv_in[gi] & r_pend[gi] & ~w_grant_oh[gi];
    end

    assign w_drop_sum = {1'b0, r_drop_cnt} + (DROP_W + 1)'($countones(w_drop));

    always_comb begin
        w_state_next   = r_state;
        w_issue        = 1'b0;
        w_dv_next      = 3'b000;
        w_wait_next    = r_wait_cnt;
        w_hold_next    = r_hold_cnt;
        w_timeout_next = r_timeout;
        unique case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_issue      = 1'b1;
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_dv_next    = 3'b001 << r_sel;
                w_wait_next  = '0;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (io_bus.dds_done_in) begin
                    w_hold_next  = '0;
                    w_state_next = (HOLDOFF_CYCLES == 0) ? S_IDLE : S_HOLDOFF;
                end else if (int'(r_wait_cnt) == TIMEOUT_CYCLES - 1) begin
                    w_timeout_next = 1'b1;
                    w_hold_next    = '0;
                    w_state_next   = (HOLDOFF_CYCLES == 0) ? S_IDLE : S_HOLDOFF;
                end else begin
                    w_wait_next = r_wait_cnt + WAIT_W'(1);
                end
            end
            S_HOLDOFF: begin
                if (int'(r_hold_cnt) >= HOLDOFF_CYCLES - 1) w_state_next = S_IDLE;
                else                                        w_hold_next  = r_hold_cnt + HOLD_W'(1);
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) r_state <= S_IDLE;
        else             r_state <= w_state_next;
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_pend      <= '0;
            r_dv        <= '0;
            r_rr_ptr    <= '0;
            r_sel       <= '0;
            r_freq_val  <= '0;
            r_phase_val <= '0;
            r_amp_val   <= '0;
            r_freq_out  <= '0;
            r_phase_out <= '0;
            r_amp_out   <= '0;
            r_wait_cnt  <= '0;
            r_hold_cnt  <= '0;
            r_timeout   <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            r_pend     <= w_pend_next;
            r_dv       <= w_dv_next;
            r_wait_cnt <= w_wait_next;
            r_hold_cnt <= w_hold_next;
            r_timeout  <= w_timeout_next;
            r_drop_cnt <= w_drop_sum[DROP_W] ? {DROP_W{1'b1}} : w_drop_sum[DROP_W-1:0];
            if (w_issue) begin
                r_sel    <= w_grant_idx;
                r_rr_ptr <= rr_next(w_grant_idx);
            end
            if (w_grant_oh[0]) r_freq_out  <= r_freq_val;
            if (w_grant_oh[1]) r_phase_out <= r_phase_val;
            if (w_grant_oh[2]) r_amp_out   <= r_amp_val;
            if (w_dv_in[0])    r_freq_val  <= io_bus.freq_in;
            if (w_dv_in[1])    r_phase_val <= io_bus.phase_in;
            if (w_dv_in[2])    r_amp_val   <= io_bus.amp_in;
        end
    end

    assign io_bus.freq_out       = r_freq_out;
    assign io_bus.phase_out      = r_phase_out;
    assign io_bus.amp_out        = r_amp_out;
    assign io_bus.freq_dv_out    = r_dv[0];
    assign io_bus.phase_dv_out   = r_dv[1];
    assign io_bus.amp_dv_out     = r_dv[2];
    assign io_bus.busy_out       = (r_state != S_IDLE);
    assign io_bus.timeout_out    = r_timeout;
    assign io_bus.drop_count_out = r_drop_cnt;
endmodule

// File: tb/tb_dds_update_scheduler.sv
// Self-checking bench for dds_update_scheduler: table vectors, hand-written
// corner sequences and a randomized run against an edge-level reference model.
module tb_dds_update_scheduler;
    localparam int H  = 16;
    localparam int T  = 4096;
    localparam int DW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dds_update_scheduler_if #(.DROP_W(DW)) bus ();

    dds_update_scheduler #(
        .HOLDOFF_CYCLES(H),
        .TIMEOUT_CYCLES(T),
        .DROP_W        (DW)
    ) dut (
        .clk_in    (clk),
        .reset_n_in(rst_n),
        .io_bus    (bus)
    );

    int n_checks  = 0;
    int n_fail    = 0;
    bit freq_hold = 1'b0;

    typedef struct {
        logic [2:0]  mask;
        logic [47:0] f;
        logic [13:0] p;
        logic [9:0]  a;
        int          n;
        int          o0;
        int          o1;
        int          o2;
    } vec_t;
    vec_t vecs[5];

    // Reference model state (edge-indexed, transaction level)
    int          m_e, m_g, m_field, m_ready, m_ptr, m_drop;
    bit          m_waiting, m_timeout;
    bit          m_pend[3];
    logic [47:0] m_val[3];
    logic [47:0] m_out[3];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] snap();
        return 128'({bus.amp_dv_out, bus.phase_dv_out, bus.freq_dv_out, bus.busy_out,
                     bus.timeout_out, bus.drop_count_out, bus.freq_out, bus.phase_out, bus.amp_out});
    endfunction

    function automatic logic [47:0] out_of(input int f);
        case (f)
            0:       return bus.freq_out;
            1:       return 48'(bus.phase_out);
            2:       return 48'(bus.amp_out);
            default: return 48'h0;
        endcase
    endfunction

    task automatic clear_pulses();
        bus.freq_dv_in  = freq_hold;
        bus.phase_dv_in = 1'b0;
        bus.amp_dv_in   = 1'b0;
        bus.dds_done_in = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        clear_pulses();
    endtask

    task automatic pulse_done();
        bus.dds_done_in = 1'b1;
        tick();
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        freq_hold  = 1'b0;
        clear_pulses();
        bus.freq_in  = '0;
        bus.phase_in = '0;
        bus.amp_in   = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_issue(input int budget, output int field, output int n, output bit found);
        logic [2:0] dv;
        found = 1'b0;
        field = -1;
        n     = 0;
        while (!found && n < budget) begin
            tick();
            n++;
            dv = {bus.amp_dv_out, bus.phase_dv_out, bus.freq_dv_out};
            if (dv != 3'b000) begin
                found = 1'b1;
                field = dv[0] ? 0 : (dv[1] ? 1 : 2);
                check("dv_onehot", 128'($countones(dv)), 128'(1));
                $display("issue: field=%0d value=0x%0h after %0d cycles", field, out_of(field), n);
            end
        end
    endtask

    task automatic model_init();
        m_e = 0; m_g = -100; m_field = 0; m_ready = 0; m_ptr = 0; m_drop = 0;
        m_waiting = 1'b0; m_timeout = 1'b0;
        for (int f = 0; f < 3; f++) begin
            m_pend[f] = 1'b0; m_val[f] = '0; m_out[f] = '0;
        end
    endtask

    // Advance the model by one clock edge with the inputs sampled on that edge.
    task automatic model_step(input logic [2:0] dv, input logic [47:0] fv, input logic [13:0] pv,
                              input logic [9:0] av, input logic done);
        int gr;
        m_e++;
        if (m_waiting && m_e >= m_g + 2) begin
            if (done) begin
                m_waiting = 1'b0;
                m_ready   = m_e + H + 1;
            end else if (m_e == m_g + 1 + T) begin
                m_timeout = 1'b1;
                m_waiting = 1'b0;
                m_ready   = m_e + H + 1;
            end
        end
        gr = -1;
        if (!m_waiting && m_e >= m_ready) begin
            for (int k = 0; k < 3; k++) begin
                if (gr < 0 && m_pend[(m_ptr + k) % 3]) gr = (m_ptr + k) % 3;
            end
        end
        if (gr >= 0) begin
            m_out[gr]  = m_val[gr];
            m_pend[gr] = 1'b0;
            m_ptr      = (gr + 1) % 3;
            m_g        = m_e;
            m_field    = gr;
            m_waiting  = 1'b1;
            $display("rand issue: field=%0d value=0x%0h edge=%0d", gr, m_out[gr], m_e);
        end
        for (int f = 0; f < 3; f++) begin
            if (dv[f]) begin
                if (m_pend[f] && m_drop < 65535) m_drop++;
                m_val[f]  = (f == 0) ? fv : ((f == 1) ? 48'(pv) : 48'(av));
                m_pend[f] = 1'b1;
            end
        end
    endtask

    function automatic logic [127:0] model_exp();
        logic [2:0]  dv;
        logic        busy;
        logic [15:0] d16;
        dv = 3'b000;
        if (m_e == m_g + 1) dv[m_field] = 1'b1;
        busy = m_waiting || (m_e <= m_ready - 2);
        d16  = 16'(m_drop);
        return 128'({dv, busy, m_timeout, d16, m_out[0], m_out[1][13:0], m_out[2][9:0]});
    endfunction

    initial begin
        int          f, n, k, exp_f;
        int          seq[4];
        bit          found;
        logic [2:0]  rdv;
        logic [47:0] rf, exp_v;
        logic [13:0] rp;
        logic [9:0]  ra;
        logic        rdone;

        vecs[0] = '{mask: 3'b111, f: 48'h1,            p: 14'h2A5,  a: 10'h3FF, n: 3, o0: 0, o1: 1, o2: 2};
        vecs[1] = '{mask: 3'b110, f: 48'h0,            p: 14'h1234, a: 10'h155, n: 2, o0: 1, o1: 2, o2: 0};
        vecs[2] = '{mask: 3'b101, f: 48'hFEDCBA987654, p: 14'h0,    a: 10'h001, n: 2, o0: 0, o1: 2, o2: 0};
        vecs[3] = '{mask: 3'b100, f: 48'h0,            p: 14'h0,    a: 10'h2AA, n: 1, o0: 2, o1: 0, o2: 0};
        vecs[4] = '{mask: 3'b011, f: 48'h0000FFFF0000, p: 14'h3FFF, a: 10'h0,   n: 2, o0: 0, o1: 1, o2: 0};

        clear_pulses();
        bus.freq_in = '0; bus.phase_in = '0; bus.amp_in = '0;
        @(negedge clk);
        check("reset_state", snap(), 128'(0));

        // Single freq request with done 50 cycles after the issue
        do_reset();
        bus.freq_in = 48'h123456789ABC; bus.freq_dv_in = 1'b1;
        wait_issue(40, f, n, found);
        check("single_field", 128'(f), 128'(0));
        check("single_latency", 128'(n), 128'(3));
        check("single_value", 128'(bus.freq_out), 128'(48'h123456789ABC));
        tick();
        check("single_pulse_width", 128'({bus.amp_dv_out, bus.phase_dv_out, bus.freq_dv_out}), 128'(0));
        repeat (48) tick();
        check("single_busy_wait", 128'(bus.busy_out), 128'(1));
        pulse_done();
        for (int j = 0; j < H; j++) begin
            check("single_busy_holdoff", 128'(bus.busy_out), 128'(1));
            tick();
        end
        check("single_idle_after_holdoff", 128'(bus.busy_out), 128'(0));

        // Table-driven simultaneous requests from a fresh reset
        for (int v = 0; v < 5; v++) begin
            do_reset();
            bus.freq_in = vecs[v].f; bus.phase_in = vecs[v].p; bus.amp_in = vecs[v].a;
            bus.freq_dv_in  = vecs[v].mask[0];
            bus.phase_dv_in = vecs[v].mask[1];
            bus.amp_dv_in   = vecs[v].mask[2];
            for (int j = 0; j < vecs[v].n; j++) begin
                exp_f = (j == 0) ? vecs[v].o0 : ((j == 1) ? vecs[v].o1 : vecs[v].o2);
                exp_v = (exp_f == 0) ? vecs[v].f : ((exp_f == 1) ? 48'(vecs[v].p) : 48'(vecs[v].a));
                wait_issue(40, f, n, found);
                check("vec_found", 128'(found), 128'(1));
                check("vec_field", 128'(f), 128'(exp_f));
                check("vec_spacing", 128'(n), 128'((j == 0) ? 3 : H + 2));
                check("vec_value", 128'(out_of(f)), 128'(exp_v));
                tick(); tick();
                pulse_done();
            end
            wait_issue(40, f, n, found);
            check("vec_no_extra", 128'(found), 128'(0));
        end

        // Coalescing two phase requests while waiting on a freq transfer
        do_reset();
        bus.freq_in = 48'h42; bus.freq_dv_in = 1'b1;
        wait_issue(40, f, n, found);
        bus.phase_in = 14'h0011; bus.phase_dv_in = 1'b1; tick();
        bus.phase_in = 14'h0022; bus.phase_dv_in = 1'b1; tick();
        tick();
        pulse_done();
        wait_issue(40, f, n, found);
        check("coal_field", 128'(f), 128'(1));
        check("coal_spacing", 128'(n), 128'(H + 2));
        check("coal_value", 128'(bus.phase_out), 128'(14'h0022));
        check("coal_drops", 128'(bus.drop_count_out), 128'(1));

        // Fairness with freq requested every cycle
        do_reset();
        freq_hold = 1'b1; bus.freq_in = 48'h55; bus.freq_dv_in = 1'b1;
        wait_issue(40, seq[0], n, found);
        bus.phase_in = 14'h0ABC; bus.phase_dv_in = 1'b1; tick();
        tick();
        pulse_done();
        for (int j = 1; j < 4; j++) begin
            wait_issue(40, seq[j], n, found);
            if (j == 1) check("fair_phase_value", 128'(bus.phase_out), 128'(14'h0ABC));
            tick(); tick();
            pulse_done();
        end
        check("fair_order", 128'({8'(seq[0]), 8'(seq[1]), 8'(seq[2]), 8'(seq[3])}), 128'(32'h00010000));
        freq_hold = 1'b0;

        // Watchdog timeout on an amp transfer, then a pending freq issues
        do_reset();
        bus.amp_in = 10'h1C3; bus.amp_dv_in = 1'b1;
        wait_issue(40, f, n, found);
        check("to_field", 128'(f), 128'(2));
        bus.freq_in = 48'hABCDEF; bus.freq_dv_in = 1'b1;
        k = 0;
        while (bus.timeout_out !== 1'b1 && k < T + 200) begin
            tick();
            k++;
        end
        check("to_cycles", 128'(k), 128'(T));
        wait_issue(40, f, n, found);
        check("to_next_field", 128'(f), 128'(0));
        check("to_next_spacing", 128'(n), 128'(H + 2));
        check("to_sticky", 128'(bus.timeout_out), 128'(1));

        // Asynchronous reset while an issue strobe is high and phase is pending
        do_reset();
        bus.freq_in = 48'h777; bus.freq_dv_in = 1'b1;
        bus.phase_in = 14'h123; bus.phase_dv_in = 1'b1;
        wait_issue(40, f, n, found);
        check("rst_pre_dv", 128'(bus.freq_dv_out), 128'(1));
        rst_n = 1'b0;
        #1;
        check("rst_async", snap(), 128'(0));
        tick(); tick();
        rst_n = 1'b1;
        tick();
        pulse_done();
        wait_issue(40, f, n, found);
        check("rst_nothing_pending", 128'(found), 128'(0));
        check("rst_outputs", snap(), 128'(0));

        // Randomized run against the reference model
        do_reset();
        model_init();
        for (int i = 0; i < 3000; i++) begin
            if (i > 0) check("rand_cycle", snap(), model_exp());
            rdv   = {($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0)};
            rf    = {16'($urandom), $urandom};
            rp    = 14'($urandom);
            ra    = 10'($urandom);
            rdone = ($urandom_range(0, 5) == 0);
            bus.freq_in = rf; bus.phase_in = rp; bus.amp_in = ra;
            bus.freq_dv_in = rdv[0]; bus.phase_dv_in = rdv[1]; bus.amp_dv_in = rdv[2];
            bus.dds_done_in = rdone;
            model_step(rdv, rf, rp, ra, rdone);
            @(negedge clk);
        end
        check("rand_final", snap(), model_exp());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
